instr_encoder: RTL and testbench

- Packs decoded RISC-V instruction fields (opcode, register indices, funct fields, signed immediate) back into 32-bit instruction words. It is the inverse of the immediate-extraction path in the decode stage.
- Used by the program-load path and by self-checking benches to build instruction memory images.
- Accepts one field tuple per valid/ready handshake, buffers the packed word in a one-entry output register, and tags it with an auto-incrementing byte address.
- Rejects unsupported opcodes and out-of-range immediates with a sticky error state.

---
 rtl/instr_encoder.sv | 122 ++++++++++++
 tb/tb_instr_encoder.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// Packs RISC-V field tuples into 32-bit instruction words with a one-entry output buffer and byte address tag.
// Optional macro ENCODER_RANGE_CHECK_EN enables immediate range / branch alignment errors (codes 2 and 3).
module instr_encoder #(
  parameter int          ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [6:0]        op_i,
  input  logic [4:0]        rd_i,
  input  logic [4:0]        rs1_i,
  input  logic [4:0]        rs2_i,
  input  logic [2:0]        funct3_i,
  input  logic [6:0]        funct7_i,
  input  logic [31:0]       imm_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [31:0]       data_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              err_o,
  output logic [1:0]        err_code_o,
  input  logic              clear_i
);
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {S_EMPTY, S_FULL, S_ERR} state_t;

  state_t              r_state, w_next;
  logic [31:0]         r_data;
  logic [ADDR_W-1:0]   r_addr;
  logic [1:0]          r_err_code;
  logic [31:0]         w_word;
  logic [1:0]          w_code;
  logic                w_push, w_pop, w_load, w_set_err;

`ifdef ENCODER_RANGE_CHECK_EN
  logic w_imm12_ok, w_br_ok;
  assign w_imm12_ok = ($signed(imm_i) >= -32'sd2048) && ($signed(imm_i) <= 32'sd2047);
  assign w_br_ok    = ($signed(imm_i) >= -32'sd4096) && ($signed(imm_i) <= 32'sd4094);
`else
  // Upper immediate bits are simply truncated when the checks are not built.
  logic w_unused_imm;
  assign w_unused_imm = ^imm_i[31:13];
`endif

  always_comb begin
    w_word = '0;
    w_code = 2'd0;
    case (op_i)
      OP_R: w_word = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, op_i};
      OP_I, OP_LOAD: begin
        w_word = {imm_i[11:0], rs1_i, funct3_i, rd_i, op_i};
`ifdef ENCODER_RANGE_CHECK_EN
        if (!w_imm12_ok) w_code = 2'd2;
`endif
      end
      OP_STORE: begin
        w_word = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], op_i};
`ifdef ENCODER_RANGE_CHECK_EN
        if (!w_imm12_ok) w_code = 2'd2;
`endif
      end
      OP_BRANCH: begin
        // b = imm[12:1]: {b[11], b[9:4], ..., b[3:0], b[10]}
        w_word = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i, imm_i[4:1], imm_i[11], op_i};
`ifdef ENCODER_RANGE_CHECK_EN
        if (!w_br_ok)      w_code = 2'd2;
        else if (imm_i[0]) w_code = 2'd3;
`endif
      end
      default: w_code = 2'd1;
    endcase
  end

  assign out_valid_o = (r_state == S_FULL);
  assign in_ready_o  = (r_state != S_ERR) && ((r_state == S_EMPTY) || out_ready_i);
  assign w_push      = in_valid_i && in_ready_o;
  assign w_pop       = out_valid_o && out_ready_i;

  always_comb begin
    w_next    = r_state;
    w_load    = 1'b0;
    w_set_err = 1'b0;
    if (w_push && (w_code != 2'd0)) begin
      w_next    = S_ERR;
      w_set_err = 1'b1;
    end else if (w_push) begin
      w_next = S_FULL;
      w_load = 1'b1;
    end else if (w_pop) begin
      w_next = S_EMPTY;
    end else if ((r_state == S_ERR) && clear_i) begin
      w_next = S_EMPTY;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= S_EMPTY;
      r_data     <= '0;
      r_addr     <= ADDR_W'(BASE_ADDR);
      r_err_code <= 2'd0;
    end else begin
      r_state <= w_next;
      if (w_load) r_data <= w_word;
      if (w_pop)  r_addr <= r_addr + ADDR_W'(4);
      if (w_set_err)                          r_err_code <= w_code;
      else if ((r_state == S_ERR) && clear_i) r_err_code <= 2'd0;
    end
  end

  assign data_o     = r_data;
  assign addr_o     = r_addr;
  assign err_o      = (r_state == S_ERR);
  assign err_code_o = r_err_code;
endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: driver queues expected words, negedge monitor checks each pop.
module tb_instr_encoder;
  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready, err, clear;
  logic [6:0]  op, f7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [31:0] imm, data;
  logic [7:0]  addr;
  logic [1:0]  err_code;
  logic        v2, rdy2, one2, ov2, err2;
  logic [31:0] data2;
  logic [3:0]  addr2;
  logic [1:0]  code2;

  int n_tests = 0, n_fail = 0;

  typedef struct {
    logic [31:0] data;
    logic [7:0]  addr;
    logic        br;
    logic [31:0] imm;
  } exp_t;
  exp_t        q[$];
  logic [7:0]  m_addr;

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(8), .BASE_ADDR(0)) u_dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .op_i(op), .rd_i(rd), .rs1_i(rs1), .rs2_i(rs2), .funct3_i(f3), .funct7_i(f7),
    .imm_i(imm), .out_valid_o(out_valid), .out_ready_i(out_ready), .data_o(data),
    .addr_o(addr), .err_o(err), .err_code_o(err_code), .clear_i(clear));

  instr_encoder #(.ADDR_W(4), .BASE_ADDR(12)) u_wrap (
    .clk_i(clk), .rst_i(rst), .in_valid_i(v2), .in_ready_o(rdy2),
    .op_i(op), .rd_i(rd), .rs1_i(rs1), .rs2_i(rs2), .funct3_i(f3), .funct7_i(f7),
    .imm_i(imm), .out_valid_o(ov2), .out_ready_i(one2), .data_o(data2),
    .addr_o(addr2), .err_o(err2), .err_code_o(code2), .clear_i(1'b0));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] dec_b(input logic [31:0] w);
    return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
  endfunction

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_word", data, 32'hx);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("word_data", data, e.data);
        chk("word_addr", {24'd0, addr}, {24'd0, e.addr});
        if (e.br) chk("branch_roundtrip", dec_b(data), e.imm);
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    q.delete();
    m_addr = 8'd0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [6:0] o, input logic [4:0] d, input logic [4:0] s1,
                      input logic [4:0] s2, input logic [2:0] fn3, input logic [6:0] fn7,
                      input logic [31:0] im, input bit emit, input logic [31:0] word);
    bit acc = 0;
    int k = 0;
    op = o; rd = d; rs1 = s1; rs2 = s2; f3 = fn3; f7 = fn7; imm = im;
    in_valid = 1'b1;
    while (!acc && k < 20) begin
      @(negedge clk);
      if (in_ready) begin
        acc = 1;
        if (emit) begin
          q.push_back('{data: word, addr: m_addr, br: (o == 7'h63), imm: im});
          m_addr = m_addr + 8'd4;
        end
      end
      @(posedge clk); #1;
      k++;
    end
    in_valid = 1'b0;
    if (!acc) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    chk("clear_err", {31'd0, err}, 32'd0);
    chk("clear_code", {30'd0, err_code}, 32'd0);
    chk("clear_ready", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    in_valid = 0; out_ready = 1; clear = 0; v2 = 0; one2 = 1;
    op = 0; rd = 0; rs1 = 0; rs2 = 0; f3 = 0; f7 = 0; imm = 0;
    do_reset();
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_data",  data, 32'd0);
    chk("rst_addr",  {24'd0, addr}, 32'd0);
    chk("rst_err",   {31'd0, err}, 32'd0);
    chk("rst_code",  {30'd0, err_code}, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);

    // Address wrap on the 4-bit instance: 12 -> 0
    op = 7'h33; rd = 3; rs1 = 1; rs2 = 2; f3 = 0; f7 = 0; imm = 0;
    v2 = 1'b1;
    @(posedge clk); #1;
    chk("wrap_first_addr", {28'd0, addr2}, 32'd12);
    @(posedge clk); #1;
    v2 = 1'b0;
    chk("wrap_second_addr", {28'd0, addr2}, 32'd0);
    chk("wrap_second_valid", {31'd0, ov2}, 32'd1);
    chk("wrap_data", data2, 32'h002081B3);
    idle(2);

    send(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1, 32'h002081B3);
    idle(2);
    do_reset();

    send(7'h13, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF, 1, 32'hFFF00293);
    send(7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8,       1, 32'h0020A423);
    send(7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFFFFF8, 1, 32'hFE208CE3);
    idle(3);

    // Back-pressure: sub x4,x5,x6 held, then lw x9,-4(x2) pushed on the pop cycle
    out_ready = 1'b0;
    send(7'h33, 5'd4, 5'd5, 5'd6, 3'd0, 7'h20, 32'd0, 1, 32'h40628233);
    repeat (3) begin
      @(negedge clk);
      chk("bp_ready_low", {31'd0, in_ready}, 32'd0);
      chk("bp_data_stable", data, 32'h40628233);
      chk("bp_addr_stable", {24'd0, addr}, 32'h0C);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(7'h03, 5'd9, 5'd2, 5'd0, 3'd2, 7'd0, 32'hFFFFFFFC, 1, 32'hFFC12483);
    chk("bp_stay_full", {31'd0, out_valid}, 32'd1);
    idle(2);

    send(7'h7F, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0, 0, 32'd0);
    chk("badop_err", {31'd0, err}, 32'd1);
    chk("badop_code", {30'd0, err_code}, 32'd1);
    chk("badop_novalid", {31'd0, out_valid}, 32'd0);
    chk("badop_ready", {31'd0, in_ready}, 32'd0);
    chk("badop_addr", {24'd0, addr}, 32'h14);
    do_clear();
    send(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1, 32'h002081B3);
    idle(2);

`ifdef ENCODER_RANGE_CHECK_EN
    send(7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 0, 32'd0);
    chk("range_err", {31'd0, err}, 32'd1);
    chk("range_code", {30'd0, err_code}, 32'd2);
    chk("range_addr", {24'd0, addr}, 32'h18);
    do_clear();
    send(7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd5, 0, 32'd0);
    chk("align_code", {30'd0, err_code}, 32'd3);
    do_clear();
`else
    send(7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 1, 32'h80000013);
    idle(2);
    chk("trunc_noerr", {31'd0, err}, 32'd0);
`endif

    // Reset with a word buffered discards it
    out_ready = 1'b0;
    send(7'h33, 5'd7, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1, 32'h002083B3);
    chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    do_reset();
    out_ready = 1'b1;
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_addr", {24'd0, addr}, 32'd0);
    chk("midrst_data", data, 32'd0);
    idle(2);

    chk("queue_drained", q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
